axis_tag_slice: RTL
===================

AXIS_TAG_SLICE -- requirements
Module: axis_tag_slice

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of s_tdata/m_tdata.
REQ-002 SHALL have parameter USER_WIDTH, default 8: width of tag counter and m_tuser.
REQ-003 SHALL have parameter PACKET_MODE, default 0: 0 = tag counts beats, 1 = tag counts packets (tlast-delimited).
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous tag-counter clear, active high.
REQ-007 SHALL have port s_tdata  input  DATA_WIDTH  upstream data.
REQ-008 SHALL have port s_tlast  input  1  upstream end-of-packet.
REQ-009 SHALL have port s_tvalid  input  1  upstream valid.
REQ-010 SHALL have port s_tready  output  1  upstream ready, registered.
REQ-011 SHALL have port m_tdata  output  DATA_WIDTH  downstream data, registered.
REQ-012 SHALL have port m_tlast  output  1  downstream end-of-packet, registered.
REQ-013 SHALL have port m_tuser  output  USER_WIDTH  tag of the current m_tdata beat, registered.
REQ-014 SHALL have port m_tvalid  output  1  downstream valid, registered.
REQ-015 SHALL have port m_tready  input  1  downstream ready.

Function
REQ-016 SHALL accept an input beat iff s_tvalid && s_tready at a rising edge; SHALL emit a beat iff m_tvalid && m_tready.
REQ-017 SHALL be a two-entry skid register slice: main register drives m_*; skid register holds one {tdata,tlast,tag} entry.
REQ-018 SHALL implement states EMPTY (no entries), ONE (main valid, skid empty), TWO (both valid); m_tvalid = state!=EMPTY; s_tready = state!=TWO.
REQ-019 Transitions: EMPTY--accept-->ONE; ONE--accept & !emit-->TWO; ONE--emit & !accept-->EMPTY; ONE--accept & emit-->ONE (new beat to main); TWO--emit-->ONE (skid to main); otherwise hold.
REQ-020 SHALL sustain one beat per cycle when m_tready held high; latency s accept to m_tvalid = 1 cycle.
REQ-021 SHALL preserve beat order and never drop or duplicate a beat; m_* SHALL stay stable while m_tvalid && !m_tready.
REQ-022 SHALL assign the tag at input acceptance: tag = tag counter value in that cycle (or 0 if clear is high that cycle).
REQ-023 PACKET_MODE=0: counter SHALL increment by 1 on every accepted beat.
REQ-024 PACKET_MODE=1: counter SHALL increment by 1 on every accepted beat with s_tlast=1; all beats of one packet carry the same tag.
REQ-025 Counter SHALL wrap modulo 2^USER_WIDTH (all-ones + 1 -> 0), no saturation, no flag.
REQ-026 clear SHALL take priority: counter next = 0, or 1 if a beat is accepted that cycle that would increment it per REQ-023/024.
REQ-027 clear SHALL NOT affect beats already held in main or skid registers, nor the handshake state.
REQ-028 s_tlast SHALL pass through to m_tlast unchanged in both modes.

Reset
REQ-029 While resetn low: state=EMPTY, m_tvalid=0, s_tready=0, m_tdata=0, m_tlast=0, m_tuser=0, skid contents=0, counter=0.
REQ-030 s_tready SHALL rise on the first rising edge after resetn deasserts; no beat is accepted before then.
REQ-031 resetn asserted mid-operation SHALL discard all held beats immediately and apply REQ-029 asynchronously.

Verification
REQ-032 PACKET_MODE=0, m_tready=1, send data 0x10..0x14 back-to-back -> m_tdata 0x10..0x14 one per cycle from 1 cycle later, m_tuser 0..4, s_tready stays 1.
REQ-033 PACKET_MODE=0, m_tready=0, send 3 beats -> accepts 2, s_tready falls after second accept; m_tready=1 -> beats out in order, tags 0,1,2, no stall bubble.
REQ-034 PACKET_MODE=1, packets of 3,1,2 beats (tlast on last) -> m_tuser 0,0,0,1,2,2; m_tlast mirrors input.
REQ-035 USER_WIDTH=2, PACKET_MODE=0, 6 beats -> tags 0,1,2,3,0,1.
REQ-036 Counter at 5, clear high in same cycle as accepted beat -> that beat tag 0, next beat tag 1; beats queued before clear keep tags 3,4.
REQ-037 Random valid/ready, resetn pulsed low mid-stream -> m_tvalid=0 and s_tready=0 during reset, next beat after release tagged 0; scoreboard shows no loss/duplication outside reset.

Source files
------------

// File: rtl/axis_tag_slice.sv
// axis_tag_slice: two-entry AXI-Stream skid register slice that stamps every
// accepted beat with a tag from a free-running counter.
//
// The counter counts accepted beats (PACKET_MODE=0) or accepted tlast beats
// (PACKET_MODE=1). It wraps modulo 2^USER_WIDTH. The tag is captured at input
// acceptance and travels with the beat through the main/skid registers.
//
// Ports:
//   clock            sole clock, rising edge
//   resetn           asynchronous active-low reset
//   clear            synchronous tag-counter clear, active high
//   s_tdata/s_tlast  upstream beat
//   s_tvalid         upstream valid
//   s_tready         upstream ready (registered)
//   m_tdata/m_tlast  downstream beat (registered)
//   m_tuser          tag of the current m_tdata beat (registered)
//   m_tvalid         downstream valid (registered)
//   m_tready         downstream ready
module axis_tag_slice #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 8,
  parameter int PACKET_MODE = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;

  logic [USER_WIDTH-1:0] tag_cnt;
  logic [USER_WIDTH-1:0] tag_cnt_nx;
  logic [USER_WIDTH-1:0] in_tag;

  logic [DATA_WIDTH-1:0] skid_tdata;
  logic                  skid_tlast;
  logic [USER_WIDTH-1:0] skid_tuser;

  logic                  accept;
  logic                  emit;
  logic                  cnt_inc;

  assign accept  = s_tvalid && s_tready;
  assign emit    = m_tvalid && m_tready;
  assign cnt_inc = accept && ((PACKET_MODE == 0) || s_tlast);

  // A beat accepted in the same cycle as clear is tagged as the first beat
  // after the clear.
  assign in_tag  = clear ? '0 : tag_cnt;

  always_comb begin
    tag_cnt_nx = clear ? USER_WIDTH'(cnt_inc) : tag_cnt + USER_WIDTH'(cnt_inc);
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !emit)      state_nx = TWO;
        else if (emit && !accept) state_nx = EMPTY;
      end
      TWO:     if (emit) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY;
      tag_cnt    <= '0;
      s_tready   <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      m_tuser    <= '0;
      skid_tdata <= '0;
      skid_tlast <= 1'b0;
      skid_tuser <= '0;
    end else begin
      state    <= state_nx;
      tag_cnt  <= tag_cnt_nx;
      // Handshake flags are registered copies of the next-state decode.
      m_tvalid <= (state_nx != EMPTY);
      s_tready <= (state_nx != TWO);

      case (state)
        EMPTY: begin
          if (accept) begin
            m_tdata <= s_tdata;
            m_tlast <= s_tlast;
            m_tuser <= in_tag;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_tdata <= s_tdata;
            m_tlast <= s_tlast;
            m_tuser <= in_tag;
          end else if (accept) begin
            skid_tdata <= s_tdata;
            skid_tlast <= s_tlast;
            skid_tuser <= in_tag;
          end
        end
        TWO: begin
          if (emit) begin
            m_tdata <= skid_tdata;
            m_tlast <= skid_tlast;
            m_tuser <= skid_tuser;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
